// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / next-PC controller for the PC register.
//
// It handshakes each fetch with instruction memory and then selects the
// next PC. The priority is halt, then ret, then call, then branchTake, then
// increment. It is the only block that may load the PC register.
//
// Optional return stack: define PC_SEQ_RET_STACK_EN to build it.
// Without that macro there is no stack. call then acts as a plain branch,
// ret is ignored, and stackErr is tied low.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   pc            current PC, read back from the PC register
//   pcNext        next PC value, loaded when pcEnable is high
//   pcEnable      load strobe to the PC register
//   fetchReq      fetch request to instruction memory
//   fetchAck      instruction at pc is valid this cycle
//   stall         execute is not ready; the PC is held
//   branchTake    jump to branchTarget
//   branchTarget  jump / call destination
//   call, ret     subroutine call (push pc+1) and return (pop)
//   halt, resume  enter HALT after the current instruction, and leave it
//   halted        high while in HALT
//   stackErr      sticky return-stack overflow / underflow flag
module pc_sequencer #(
  parameter int PC_WIDTH    = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcNext,
  output logic                pcEnable,
  output logic                fetchReq,
  input  logic                fetchAck,
  input  logic                stall,
  input  logic                branchTake,
  input  logic [PC_WIDTH-1:0] branchTarget,
  input  logic                call,
  input  logic                ret,
  input  logic                halt,
  input  logic                resume,
  output logic                halted,
  output logic                stackErr
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  state_e state_q, state_d;

  // Wraps modulo 2^PC_WIDTH without any flag.
  logic [PC_WIDTH-1:0] pc_inc;
  assign pc_inc = pc + PC_WIDTH'(1);

`ifdef PC_SEQ_RET_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;  // one extra bit so the count can reach STACK_DEPTH

  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PTR_W-1:0]    sp_q;       // number of valid entries
  logic                err_q;
  logic                do_push, do_pop, err_set;
  logic                stack_full, stack_empty;
  logic [IDX_W-1:0]    wr_idx, rd_idx;

  assign stack_full  = (sp_q == PTR_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign wr_idx      = IDX_W'(sp_q);
  assign rd_idx      = IDX_W'(sp_q - PTR_W'(1));
  assign stackErr    = err_q;
`else
  assign stackErr = 1'b0;
`endif

  // Outputs are decoded from the state and the current inputs, so pcNext
  // and pcEnable appear in the same EXEC cycle that the PC register loads.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    state_d  = state_q;
    pcNext   = '0;
    pcEnable = 1'b0;
    fetchReq = 1'b0;
    halted   = 1'b0;
`ifdef PC_SEQ_RET_STACK_EN
    do_push  = 1'b0;
    do_pop   = 1'b0;
    err_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        fetchReq = 1'b1;
        if (fetchAck) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          pcEnable = 1'b1;
          state_d  = halt ? S_HALT : S_FETCH;
          if (halt) begin
            // Halting still retires the current instruction sequentially.
            pcNext = pc_inc;
`ifdef PC_SEQ_RET_STACK_EN
          end else if (ret) begin
            if (stack_empty) begin
              pcNext  = pc_inc;
              err_set = 1'b1;
            end else begin
              pcNext = stack_q[rd_idx];
              do_pop = 1'b1;
            end
          end else if (call) begin
            // On overflow the jump is still taken; only the push is dropped.
            pcNext = branchTarget;
            if (stack_full) err_set = 1'b1;
            else            do_push = 1'b1;
          end else if (branchTake) begin
            pcNext = branchTarget;
`else
          end else if (branchTake || call) begin
            pcNext = branchTarget;
          end else if (ret) begin
            pcNext = pc_inc;
`endif
          end else begin
            pcNext = pc_inc;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

`ifdef PC_SEQ_RET_STACK_EN
  // A reset that lands in the same cycle as a push or pop wins, so the
  // stack pointer is left empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (do_push)     sp_q <= sp_q + PTR_W'(1);
      else if (do_pop) sp_q <= sp_q - PTR_W'(1);
      if (err_set)     err_q <= 1'b1;
    end
  end

  // NOTE: stack storage has no reset; the pointer alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst) stack_q[wr_idx] <= pc_inc;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer.
// It runs directed scenarios first and then a randomized run. Every cycle
// is compared against a cycle-level reference model that uses a queue as
// the return stack. The bench also acts as the PC register: on the falling
// edge after a load, pc takes the expected pcNext.
module tb_pc_sequencer;
  localparam int W     = 9;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RET_STACK_EN
  localparam bit STACK_ON = 1'b1;
`else
  localparam bit STACK_ON = 1'b0;
`endif

  typedef enum int {P_IDLE, P_FETCH, P_EXEC, P_HALT} phase_e;

  logic         clk = 1'b0;
  logic         rst, fetchAck, stall, branchTake, call, ret, halt, resume;
  logic [W-1:0] pc, branchTarget;
  logic [W-1:0] pcNext;
  logic         pcEnable, fetchReq, halted, stackErr;

  int           n_tests = 0;
  int           n_fail  = 0;

  phase_e       m_phase;
  logic [W-1:0] m_stack[$];
  logic         m_err;

  pc_sequencer #(.PC_WIDTH(W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pcNext(pcNext), .pcEnable(pcEnable),
    .fetchReq(fetchReq), .fetchAck(fetchAck), .stall(stall),
    .branchTake(branchTake), .branchTarget(branchTarget), .call(call),
    .ret(ret), .halt(halt), .resume(resume), .halted(halted),
    .stackErr(stackErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_ctrl();
    rst = 1'b0; fetchAck = 1'b0; stall = 1'b0; branchTake = 1'b0;
    call = 1'b0; ret = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  // Called at a falling edge with the inputs already driven. It compares
  // every output against the model and then advances the model by one clock.
  task automatic cycle(input string tag);
    logic [W-1:0] inc, e_next;
    logic         e_en, e_req, e_hlt, do_pop, do_push, set_err;
    phase_e       n_phase;
    #1;
    inc = pc + 9'd1;
    e_next = '0; e_en = 0; e_req = 0; e_hlt = 0;
    do_pop = 0; do_push = 0; set_err = 0;
    n_phase = m_phase;
    case (m_phase)
      P_IDLE:  n_phase = P_FETCH;
      P_FETCH: begin e_req = 1; if (fetchAck) n_phase = P_EXEC; end
      P_EXEC: if (!stall) begin
        e_en = 1;
        n_phase = halt ? P_HALT : P_FETCH;
        if (halt) e_next = inc;
        else if (STACK_ON && ret) begin
          if (m_stack.size() == 0) begin e_next = inc; set_err = 1; end
          else begin e_next = m_stack[$]; do_pop = 1; end
        end else if (STACK_ON && call) begin
          e_next = branchTarget;
          if (m_stack.size() == DEPTH) set_err = 1; else do_push = 1;
        end else if (branchTake || call) e_next = branchTarget;
        else e_next = inc;
      end
      P_HALT: begin e_hlt = 1; if (resume) n_phase = P_FETCH; end
      default: ;
    endcase
    check({tag, "_en"}, {31'd0, pcEnable}, {31'd0, e_en});
    check({tag, "_req"}, {31'd0, fetchReq}, {31'd0, e_req});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, e_hlt});
    check({tag, "_err"}, {31'd0, stackErr}, {31'd0, m_err});
    if (e_en || m_phase == P_IDLE) check({tag, "_next"}, {23'd0, pcNext}, {23'd0, e_next});
    @(posedge clk);
    if (rst) begin
      m_phase = P_IDLE;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      m_phase = n_phase;
      if (do_pop)  void'(m_stack.pop_back());
      if (do_push) m_stack.push_back(inc);
      if (set_err) m_err = 1'b1;
    end
    @(negedge clk);
    if (!rst && e_en) pc = e_next;
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst = 1'b1;
    cycle("reset");
    cycle("reset");
    rst = 1'b0;
  endtask

  // Steps until the model says EXEC, acking fetches and resuming from HALT.
  task automatic to_exec();
    for (int i = 0; i < 20 && m_phase != P_EXEC; i++) begin
      clear_ctrl();
      fetchAck = 1'b1;
      resume = 1'b1;
      cycle("to_exec");
    end
    if (m_phase != P_EXEC) begin
      n_tests++;
      n_fail++;
      $display("FAIL to_exec: EXEC not reached within 20 cycles");
    end
    clear_ctrl();
  endtask

  initial begin
    logic [W-1:0] exp_v;
    clear_ctrl();
    pc = '0;
    branchTarget = '0;
    m_err = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_phase = P_IDLE;

    // Reset release, then sequential fetch/exec with immediate ack.
    do_reset();
    pc = '0;
    fetchAck = 1'b1;
    #1;
    check("idle_en", {31'd0, pcEnable}, 32'd0);
    check("idle_req", {31'd0, fetchReq}, 32'd0);
    check("idle_next", {23'd0, pcNext}, 32'd0);
    check("idle_halted", {31'd0, halted}, 32'd0);
    cycle("idle");
    for (int k = 1; k <= 3; k++) begin
      cycle("seq_fetch");
      #1;
      check("seq_en", {31'd0, pcEnable}, 32'd1);
      check("seq_next", {23'd0, pcNext}, k);
      cycle("seq_exec");
    end

    // Increment wraps from 511 to 0.
    to_exec();
    pc = 9'd511;
    #1;
    check("wrap_next", {23'd0, pcNext}, 32'd0);
    check("wrap_en", {31'd0, pcEnable}, 32'd1);
    cycle("wrap");

    // Call followed by a return.
    do_reset();
    to_exec();
    pc = 9'd10; call = 1'b1; branchTarget = 9'd100;
    #1;
    check("call_next", {23'd0, pcNext}, 32'd100);
    cycle("call");
    to_exec();
    pc = 9'd105; ret = 1'b1;
    #1;
    exp_v = STACK_ON ? 9'd11 : 9'd106;
    check("ret_next", {23'd0, pcNext}, {23'd0, exp_v});
    cycle("ret");
    check("ret_err", {31'd0, stackErr}, 32'd0);

    // Overflow on the fifth call, underflow on the fifth return.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      to_exec();
      pc = W'(i); call = 1'b1; branchTarget = 9'd300;
      cycle("ovf_call");
      check("ovf_err", {31'd0, stackErr}, {31'd0, STACK_ON && i == 4});
    end
    for (int i = 0; i < 5; i++) begin
      to_exec();
      pc = 9'd200; ret = 1'b1;
      #1;
      exp_v = (STACK_ON && i < 4) ? W'(4 - i) : 9'd201;
      check("pop_next", {23'd0, pcNext}, {23'd0, exp_v});
      cycle("pop");
    end
    check("pop_err", {31'd0, stackErr}, {31'd0, STACK_ON});

    // Fetch wait states followed by execute stalls.
    do_reset();
    cycle("idle2");
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_req", {31'd0, fetchReq}, 32'd1);
      cycle("wait");
    end
    fetchAck = 1'b1;
    #1;
    check("ack_req", {31'd0, fetchReq}, 32'd1);
    cycle("ack");
    clear_ctrl();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stall_en", {31'd0, pcEnable}, 32'd0);
      check("stall_req", {31'd0, fetchReq}, 32'd0);
      cycle("stall");
    end
    stall = 1'b0;
    exp_v = pc + 9'd1;
    #1;
    check("unstall_en", {31'd0, pcEnable}, 32'd1);
    check("unstall_next", {23'd0, pcNext}, {23'd0, exp_v});
    cycle("unstall");

    // Halt, resume, then a reset taken while halted.
    to_exec();
    pc = 9'd20; halt = 1'b1;
    #1;
    check("halt_next", {23'd0, pcNext}, 32'd21);
    check("halt_en", {31'd0, pcEnable}, 32'd1);
    cycle("halt");
    clear_ctrl();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("halted", {31'd0, halted}, 32'd1);
      cycle("halted");
    end
    resume = 1'b1;
    cycle("resume");
    clear_ctrl();
    #1;
    check("resume_req", {31'd0, fetchReq}, 32'd1);
    cycle("after_resume");
    to_exec();
    halt = 1'b1;
    cycle("halt2");
    clear_ctrl();
    rst = 1'b1;
    cycle("halt_rst");
    rst = 1'b0;
    #1;
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    cycle("post_rst");

    // Randomized run.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      fetchAck     = $urandom_range(0, 1) == 1;
      stall        = ($urandom_range(0, 3) == 0);
      branchTake   = ($urandom_range(0, 3) == 0);
      call         = ($urandom_range(0, 3) == 0);
      ret          = ($urandom_range(0, 3) == 0);
      halt         = ($urandom_range(0, 9) == 0);
      resume       = ($urandom_range(0, 2) == 0);
      branchTarget = W'($urandom);
      if ($urandom_range(0, 15) == 0) pc = W'($urandom);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
